// File: rtl/layer_mixer_if.sv
// layer_mixer_if: pixel/sync bundle between a video source and layer_mixer.
// master drives layers and raw timing; slave returns composited pixels.
interface layer_mixer_if;
  logic [23:0] layer0;
  logic [23:0] layer1;
  logic [23:0] layer2;
  logic [23:0] layer3;
  logic        hsync_in;
  logic        vsync_in;
  logic        blank_in;
  logic        screen_change;
  logic [23:0] pixel_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        blank_out;
  logic        fade_done;

  modport master (
    output layer0, layer1, layer2, layer3,
    output hsync_in, vsync_in, blank_in, screen_change,
    input  pixel_out, hsync_out, vsync_out, blank_out, fade_done
  );

  modport slave (
    input  layer0, layer1, layer2, layer3,
    input  hsync_in, vsync_in, blank_in, screen_change,
    output pixel_out, hsync_out, vsync_out, blank_out, fade_done
  );
endinterface

// File: rtl/layer_mixer.sv
// layer_mixer: 4-layer priority compositor with 2-stage pixel pipe and screen fade.
// Define LAYER_MIXER_FADE_EN to build the fade FSM and channel scaler.
module layer_mixer #(
  parameter int unsigned SYNC_DELAY      = 3,
  parameter logic [23:0] BG_COLOR        = 24'h000000,
  parameter int unsigned FRAMES_PER_STEP = 2
) (
  input logic           pixel_clk,
  input logic           reset,
  layer_mixer_if.slave  bus
);

  localparam int unsigned N = SYNC_DELAY + 2;

  typedef struct packed {
    logic hs;
    logic vs;
    logic bl;
  } sync_t;

  sync_t       sync_q [N];
  logic [23:0] sel_q, sel_d;
  logic [23:0] pix_q, pix_d;
  logic [23:0] scaled;

  always_comb begin
    sel_d = BG_COLOR;
    if (bus.layer0 != 24'h0)      sel_d = bus.layer0;
    else if (bus.layer1 != 24'h0) sel_d = bus.layer1;
    else if (bus.layer2 != 24'h0) sel_d = bus.layer2;
    else if (bus.layer3 != 24'h0) sel_d = bus.layer3;
  end

`ifdef LAYER_MIXER_FADE_EN
  typedef enum logic [1:0] {
    HOLD,
    BLACK,
    FADING
  } state_t;

  localparam logic [7:0] FPS_M1 = 8'(FRAMES_PER_STEP - 1);

  state_t     state_q, state_d;
  logic [4:0] level_q, level_d;
  logic [7:0] cnt_q, cnt_d;
  logic       vs_q;
  logic       done_q;
  logic       boundary;

  function automatic logic [7:0] scale(
    input logic [7:0] c,
    input logic [4:0] lv
  );
    logic [12:0] p;
    p = 13'(c) * 13'(lv);
    return 8'(p >> 4);
  endfunction

  assign boundary = vs_q & ~bus.vsync_in;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (bus.screen_change) begin
      state_d = BLACK;
      level_d = 5'd0;
      cnt_d   = 8'd0;
    end else begin
      unique case (state_q)
        HOLD: ;
        BLACK: if (boundary) state_d = FADING;
        FADING: begin
          if (boundary) begin
            if (cnt_q == FPS_M1) begin
              cnt_d   = 8'd0;
              level_d = level_q + 5'd1;
              if (level_q == 5'd15) state_d = HOLD;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        default: state_d = HOLD;
      endcase
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state_q <= HOLD;
      level_q <= 5'd16;
      cnt_q   <= 8'd0;
      vs_q    <= 1'b1;
      done_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      vs_q    <= bus.vsync_in;
      done_q  <= (state_d == HOLD);
    end
  end

  assign scaled = {scale(sel_q[23:16], level_q),
                   scale(sel_q[15:8],  level_q),
                   scale(sel_q[7:0],   level_q)};
  assign bus.fade_done = done_q;
`else
  logic unused_sc;

  assign unused_sc     = bus.screen_change;
  assign scaled        = sel_q;
  assign bus.fade_done = 1'b1;
`endif

  // Mask with the blank bit that becomes blank_out on the same edge.
  always_comb begin
    pix_d = sync_q[N-2].bl ? 24'h0 : scaled;
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      sel_q <= 24'h0;
      pix_q <= 24'h0;
      for (int i = 0; i < N; i++) sync_q[i] <= '{hs: 1'b1, vs: 1'b1, bl: 1'b1};
    end else begin
      sel_q     <= sel_d;
      pix_q     <= pix_d;
      sync_q[0] <= '{hs: bus.hsync_in, vs: bus.vsync_in, bl: bus.blank_in};
      for (int i = 1; i < N; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign bus.pixel_out = pix_q;
  assign bus.hsync_out = sync_q[N-1].hs;
  assign bus.vsync_out = sync_q[N-1].vs;
  assign bus.blank_out = sync_q[N-1].bl;

endmodule

// File: tb/tb_layer_mixer.sv
// tb_layer_mixer: directed checks of priority, sync alignment, blanking,
// reset refill and (when built in) the fade sequence of layer_mixer.
module tb_layer_mixer;

  localparam logic [23:0] BG = 24'h123456;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  layer_mixer_if bus ();

  layer_mixer #(
    .SYNC_DELAY      (3),
    .BG_COLOR        (BG),
    .FRAMES_PER_STEP (2)
  ) dut (
    .pixel_clk (clk),
    .reset     (reset),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [23:0] obs,
                     input logic [23:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic frame();
    bus.vsync_in = 1'b1;
    tick();
    bus.vsync_in = 1'b0;
    tick();
  endtask

  initial begin
    reset             = 1'b1;
    bus.layer0        = 24'h0;
    bus.layer1        = 24'h0;
    bus.layer2        = 24'h0;
    bus.layer3        = 24'h0;
    bus.hsync_in      = 1'b0;
    bus.vsync_in      = 1'b1;
    bus.blank_in      = 1'b0;
    bus.screen_change = 1'b1;
    tick(2);
    chk("rst_pix", bus.pixel_out, 24'h0);
    chk("rst_hs", 24'(bus.hsync_out), 24'h1);
    chk("rst_vs", 24'(bus.vsync_out), 24'h1);
    chk("rst_bl", 24'(bus.blank_out), 24'h1);
    chk("rst_done", 24'(bus.fade_done), 24'h1);

    reset             = 1'b0;
    bus.screen_change = 1'b0;
    tick(4);
    chk("refill_hs_hi", 24'(bus.hsync_out), 24'h1);
    chk("refill_bl_hi", 24'(bus.blank_out), 24'h1);
    tick();
    chk("refill_hs_lo", 24'(bus.hsync_out), 24'h0);
    chk("refill_bl_lo", 24'(bus.blank_out), 24'h0);
    chk("bg_color", bus.pixel_out, BG);
    bus.hsync_in = 1'b1;
    tick(6);

    bus.layer1 = 24'hFF0000;
    bus.layer2 = 24'h00FF00;
    tick();
    chk("lat_not_1", bus.pixel_out, BG);
    tick();
    chk("prio_l1", bus.pixel_out, 24'hFF0000);
    bus.layer0 = 24'h0000FF;
    tick(2);
    chk("prio_l0", bus.pixel_out, 24'h0000FF);
    bus.layer0 = 24'h0;
    bus.layer1 = 24'h0;
    tick(2);
    chk("prio_l2", bus.pixel_out, 24'h00FF00);
    bus.layer2 = 24'h0;
    bus.layer3 = 24'h0A0B0C;
    tick(2);
    chk("prio_l3", bus.pixel_out, 24'h0A0B0C);
    bus.layer3 = 24'h0;
    tick(2);
    chk("prio_bg", bus.pixel_out, BG);

    bus.layer1   = 24'hFF0000;
    bus.hsync_in = 1'b0;
    tick();
    bus.hsync_in = 1'b1;
    tick(3);
    chk("hs_d4", 24'(bus.hsync_out), 24'h1);
    tick();
    chk("hs_d5", 24'(bus.hsync_out), 24'h0);
    tick();
    chk("hs_d6", 24'(bus.hsync_out), 24'h1);

    bus.blank_in = 1'b1;
    tick();
    bus.blank_in = 1'b0;
    tick(3);
    chk("bl_d4", 24'(bus.blank_out), 24'h0);
    chk("bl_pix_d4", bus.pixel_out, 24'hFF0000);
    tick();
    chk("bl_d5", 24'(bus.blank_out), 24'h1);
    chk("bl_pix_d5", bus.pixel_out, 24'h0);
    tick();
    chk("bl_pix_d6", bus.pixel_out, 24'hFF0000);
    bus.layer1 = 24'h0;

    bus.layer0 = 24'h808080;
    tick(2);
    chk("full_pix", bus.pixel_out, 24'h808080);

`ifdef LAYER_MIXER_FADE_EN
    bus.screen_change = 1'b1;
    tick();
    bus.screen_change = 1'b0;
    chk("blk_done", 24'(bus.fade_done), 24'h0);
    tick();
    chk("blk_pix", bus.pixel_out, 24'h0);
    frame();
    tick();
    chk("b1_pix", bus.pixel_out, 24'h0);
    frame();
    frame();
    tick();
    chk("b3_pix", bus.pixel_out, 24'h080808);
    for (int b = 4; b <= 32; b++) frame();
    tick();
    chk("b32_pix", bus.pixel_out, 24'h787878);
    chk("b32_done", 24'(bus.fade_done), 24'h0);
    frame();
    chk("b33_done", 24'(bus.fade_done), 24'h1);
    tick();
    chk("b33_pix", bus.pixel_out, 24'h808080);

    bus.screen_change = 1'b1;
    tick();
    bus.screen_change = 1'b0;
    for (int b = 1; b <= 19; b++) frame();
    tick();
    chk("lvl9_pix", bus.pixel_out, 24'h484848);
    bus.vsync_in = 1'b1;
    tick();
    bus.vsync_in      = 1'b0;
    bus.screen_change = 1'b1;
    tick();
    bus.screen_change = 1'b0;
    chk("col_done", 24'(bus.fade_done), 24'h0);
    tick();
    chk("col_pix", bus.pixel_out, 24'h0);
    frame();
    frame();
    tick();
    chk("col_b2_pix", bus.pixel_out, 24'h0);
    frame();
    tick();
    chk("col_b3_pix", bus.pixel_out, 24'h080808);

    for (int b = 1; b <= 8; b++) frame();
    tick();
    chk("lvl5_pix", bus.pixel_out, 24'h282828);
    bus.layer0 = 24'hFF4010;
    tick(2);
    chk("lvl5_mix", bus.pixel_out, 24'h4F1405);
    bus.layer0 = 24'h808080;
    reset      = 1'b1;
    tick();
    chk("mid_rst_done", 24'(bus.fade_done), 24'h1);
    chk("mid_rst_pix", bus.pixel_out, 24'h0);
    chk("mid_rst_hs", 24'(bus.hsync_out), 24'h1);
    chk("mid_rst_vs", 24'(bus.vsync_out), 24'h1);
    reset = 1'b0;
    tick(4);
    chk("post_rst_bl", 24'(bus.blank_out), 24'h1);
    chk("post_rst_pix4", bus.pixel_out, 24'h0);
    tick();
    chk("post_rst_pix5", bus.pixel_out, 24'h808080);
    chk("post_rst_done", 24'(bus.fade_done), 24'h1);
`else
    bus.screen_change = 1'b1;
    tick();
    bus.screen_change = 1'b0;
    chk("nf_done0", 24'(bus.fade_done), 24'h1);
    tick();
    chk("nf_pix0", bus.pixel_out, 24'h808080);
    frame();
    frame();
    frame();
    tick();
    chk("nf_pix3", bus.pixel_out, 24'h808080);
    chk("nf_done3", 24'(bus.fade_done), 24'h1);
    bus.layer0 = 24'hFF4010;
    tick();
    chk("nf_lat1", bus.pixel_out, 24'h808080);
    tick();
    chk("nf_mix", bus.pixel_out, 24'hFF4010);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer_mixer.md
LAYER_MIXER -- requirements
Module: layer_mixer

Interface
REQ-001 Parameter SYNC_DELAY, default 3: cycles by which the layer pixels lag the raw hsync/vsync/blank timing.
REQ-002 Parameter BG_COLOR, default 24'h000000: colour output where no layer is opaque.
REQ-003 Parameter FRAMES_PER_STEP, default 2: frames per fade brightness step (legal range 1..255).
REQ-004 pixel_clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 layer0, layer1, layer2, layer3  in  24 each  {R,G,B} blob pixels; layer0 has the highest priority; 24'h0 means transparent.
REQ-007 hsync_in, vsync_in  in  1 each  raw sync signals, active-low, aligned with hcount/vcount.
REQ-008 blank_in  in  1  raw blanking, active-high.
REQ-009 screen_change  in  1  one-cycle pulse that starts a screen transition.
REQ-010 pixel_out  out  24  composited and faded {R,G,B}.
REQ-011 hsync_out, vsync_out, blank_out  out  1 each  syncs re-timed to pixel_out.
REQ-012 fade_done  out  1  high while in state HOLD.

Function
REQ-013 Stage 1 registers the selected pixel: the first non-zero layer in the order 0,1,2,3, otherwise BG_COLOR.
REQ-014 Stage 2 registers the scaled pixel: each 8-bit channel becomes (chan*level)>>4, using a 13-bit intermediate; level is 5 bits in the range 0..16; level 16 passes the channel unchanged.
REQ-015 Latency from layerN to pixel_out is exactly 2 cycles.
REQ-016 hsync/vsync/blank pass through a shift register of SYNC_DELAY+2 stages, so the sync outputs align with pixel_out.
REQ-017 When blank_out is high, pixel_out is 24'h0, overriding layers and BG_COLOR.
REQ-018 A frame boundary is the cycle in which vsync_in is sampled low after being high (falling edge detected against a registered copy).
REQ-019 The FSM has three states: HOLD (level=16), BLACK (level=0) and FADING.
REQ-020 In any state, screen_change moves the FSM to BLACK with level 0 and frame_cnt 0; if screen_change coincides with a frame boundary, screen_change wins and the boundary is ignored.
REQ-021 BLACK moves to FADING on the next frame boundary; level stays 0.
REQ-022 In FADING, each frame boundary increments frame_cnt (8 bits); when frame_cnt equals FRAMES_PER_STEP-1, frame_cnt clears to 0 and level increments.
REQ-023 When an increment brings level to 16, the FSM moves to HOLD in that same cycle; level never exceeds 16.
REQ-024 A level change takes effect on pixel_out starting from the pixel in stage 2 on the following cycle; the change occurs mid-blanking, so no visible tearing results.
REQ-025 fade_done is registered and equals (state==HOLD).

Reset
REQ-026 While reset is high, on each clock: state=HOLD, level=16, frame_cnt=0, the vsync edge register=1, pixel_out=0, all sync pipeline stages loaded with hsync=1, vsync=1, blank=1, and fade_done=1.
REQ-027 Reset takes priority over screen_change.
REQ-028 Reset asserted mid-fade abandons the fade; the first post-reset output is a full-brightness composite after 2 cycles.

Configuration
REQ-029 Macro LAYER_MIXER_FADE_EN: when defined, the FSM, frame_cnt and the scaler are compiled in as described above.
REQ-030 When LAYER_MIXER_FADE_EN is undefined, stage 2 is a plain register (level fixed at 16), screen_change is ignored, and fade_done ties to 1; latency and sync alignment are unchanged.

Verification
REQ-031 Priority: layer0=0, layer1=24'hFF0000, layer2=24'h00FF00, blank low, HOLD -> pixel_out=24'hFF0000 exactly 2 cycles later; with all layers 0 -> BG_COLOR.
REQ-032 Alignment: SYNC_DELAY=3, a single-cycle hsync_in low pulse -> hsync_out low exactly 5 cycles later; blank_in high -> pixel_out=0 in the matching cycle.
REQ-033 Fade: FRAMES_PER_STEP=2, layer0=24'h808080 held, screen_change pulse -> 0 during BLACK; after boundary 1, 24'h000000; after boundary 3, 24'h080808; fade_done rises at boundary 33 with output 24'h808080.
REQ-034 Collision: screen_change in the same cycle as a vsync falling edge while in FADING at level 9 -> state BLACK, level 0, frame_cnt 0; that edge does not advance to FADING.
REQ-035 Reset mid-fade (level 5) -> next cycle state HOLD, fade_done=1, level 16; all sync outputs are 1 until the pipeline refills.
REQ-036 Build without LAYER_MIXER_FADE_EN: screen_change pulses -> pixel_out equals the unscaled composite with 2-cycle latency, and fade_done stays at constant 1.
